mmio_timer_core: RTL and testbench

- MMIO slot-side responder: answers one slot of the MMIO controller's slot interface (cs, rd, wr, 5-bit reg addr, 32-bit wr/rd data).
- Implements a free-running/compare timer with a sticky match flag and an interrupt output.
- Instantiated per timer slot in the MMIO subsystem; rd_data feeds the controller's read mux.

---
 rtl/mmio_timer_pkg.sv | 26 ++
 rtl/timer_prescaler.sv | 32 +++
 rtl/mmio_timer_core.sv | 156 +++++++++++++++
 tb/tb_mmio_timer_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
`default_nettype none
// ============================================================================
// mmio_timer_pkg : register offsets and bit indices for the MMIO timer slot
// Revision: 1.0
// ============================================================================
package mmio_timer_pkg;

    localparam logic [4:0] REG_CNT_LO   = 5'd0;
    localparam logic [4:0] REG_CNT_HI   = 5'd1;
    localparam logic [4:0] REG_CTRL     = 5'd2;
    localparam logic [4:0] REG_CMP_LO   = 5'd3;
    localparam logic [4:0] REG_CMP_HI   = 5'd4;
    localparam logic [4:0] REG_STATUS   = 5'd5;
    localparam logic [4:0] REG_PRESCALE = 5'd6;

    localparam int CTRL_GO       = 0;
    localparam int CTRL_CLR      = 1;
    localparam int CTRL_PERIODIC = 2;
    localparam int CTRL_IRQ_EN   = 3;

    localparam int STATUS_MATCH  = 0;

    localparam int PRESCALE_W    = 16;

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// timer_prescaler : divides clk into one tick every prescale+1 enabled cycles
// Revision: 1.0
// ============================================================================
module timer_prescaler
    import mmio_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  restart,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt;

    assign tick = en & (pcnt == prescale);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (restart || tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_timer_core.sv
`default_nettype none
// ============================================================================
// mmio_timer_core : MMIO slot responder with compare timer, sticky match, irq.
// Optional prescaler enabled by MMIO_TIMER_PRESCALE_EN.   Revision: 1.0
// ============================================================================
module mmio_timer_core
    import mmio_timer_pkg::*;
#(
    parameter int CNT_W = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cmp;
    logic [HI_W-1:0]  cnt_hi_snap;
    logic             go;
    logic             periodic;
    logic             irq_en;
    logic             match_flag;
    logic             tick;

    logic wr_en;
    logic ctrl_wr;
    logic clr_pulse;
    logic status_w1c;
    logic lo_rd;
    logic match;

    assign wr_en      = cs & write;
    assign ctrl_wr    = wr_en && (addr == REG_CTRL);
    assign clr_pulse  = ctrl_wr && wr_data[CTRL_CLR];
    assign status_w1c = wr_en && (addr == REG_STATUS) && wr_data[STATUS_MATCH];
    assign lo_rd      = cs && read && (addr == REG_CNT_LO);
    assign match      = go & tick & (count == cmp);

`ifdef MMIO_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
    logic                  prescale_wr;

    assign prescale_wr = wr_en && (addr == REG_PRESCALE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
        end else if (prescale_wr) begin
            prescale <= wr_data[PRESCALE_W-1:0];
        end
    end

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (go),
        .restart  (clr_pulse | prescale_wr),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // One-shot match freezes the count at cmp; periodic match restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr_pulse) begin
            count <= '0;
        end else if (match) begin
            if (periodic) begin
                count <= '0;
            end
        end else if (go && tick) begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            go       <= 1'b0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
        end else if (ctrl_wr) begin
            go       <= wr_data[CTRL_GO];
            periodic <= wr_data[CTRL_PERIODIC];
            irq_en   <= wr_data[CTRL_IRQ_EN];
        end else if (match && !periodic) begin
            go       <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp <= '0;
        end else if (wr_en && (addr == REG_CMP_LO)) begin
            cmp[31:0] <= wr_data;
        end else if (wr_en && (addr == REG_CMP_HI)) begin
            cmp[CNT_W-1:32] <= wr_data[HI_W-1:0];
        end
    end

    // Snapshot on the LO read so a following HI read matches it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_hi_snap <= '0;
        end else if (lo_rd) begin
            cnt_hi_snap <= count[CNT_W-1:32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_flag <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (match) begin
                match_flag <= 1'b1;
            end else if (status_w1c) begin
                match_flag <= 1'b0;
            end
            irq <= match_flag & irq_en;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_CNT_LO: rd_data = count[31:0];
            REG_CNT_HI: rd_data[HI_W-1:0] = cnt_hi_snap;
            REG_CTRL: begin
                rd_data[CTRL_GO]       = go;
                rd_data[CTRL_PERIODIC] = periodic;
                rd_data[CTRL_IRQ_EN]   = irq_en;
            end
            REG_CMP_LO: rd_data = cmp[31:0];
            REG_CMP_HI: rd_data[HI_W-1:0] = cmp[CNT_W-1:32];
            REG_STATUS: rd_data[STATUS_MATCH] = match_flag;
`ifdef MMIO_TIMER_PRESCALE_EN
            REG_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale;
`endif
            default: rd_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_core.sv
`default_nettype none
// ============================================================================
// tb_mmio_timer_core : self-checking bench for mmio_timer_core (CNT_W = 48)
// Revision: 1.0
// ============================================================================
module tb_mmio_timer_core;

    localparam logic [4:0] A_LO = 5'd0, A_HI = 5'd1, A_CTRL = 5'd2, A_CMPL = 5'd3,
                           A_CMPH = 5'd4, A_STAT = 5'd5, A_PRE = 5'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;

    longint m_cmp;
    longint m_p;
    bit     m_per;
    bit     m_ie;

    logic [31:0] d;

    mmio_timer_core #(.CNT_W(48)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .irq     (irq)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called between a negedge and the following posedge.
    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; wr_data = v;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic rd_lo(output logic [31:0] v);
        cs = 1'b1; read = 1'b1; write = 1'b0; addr = A_LO;
        #1;
        v = rd_data;
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic start_run(input longint c, input bit per, input bit ie, input int p);
        logic [31:0] v;
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_CMPL, c[31:0]);
        wr(A_CMPH, 32'h0);
        wr(A_PRE, p[31:0]);
        peek(A_PRE, v);
`ifdef MMIO_TIMER_PRESCALE_EN
        chk("prescale_rb", {32'h0, v}, {48'h0, p[15:0]});
        m_p = p;
`else
        chk("offset6_rb", {32'h0, v}, 64'h0);
        m_p = 0;
`endif
        m_cmp = c; m_per = per; m_ie = ie;
        wr(A_CTRL, {28'h0, ie, per, 2'b11});
        start_cyc = cyc;
    endtask

    // Expected state after n edges of the current run, from tick arithmetic.
    task automatic check_state(input string tag);
        longint n, t, cnt;
        bit fired, go_e, irq_e;
        logic [31:0] v;
        n = longint'(cyc - start_cyc);
        t = n / (m_p + 1);
        fired = (t >= m_cmp + 1);
        cnt = m_per ? (t % (m_cmp + 1)) : (fired ? m_cmp : t);
        go_e = m_per | !fired;
        irq_e = m_ie && (n >= (m_cmp + 1) * (m_p + 1) + 1);
        peek(A_LO, v);
        chk({tag, "_cnt"}, {32'h0, v}, {32'h0, cnt[31:0]});
        peek(A_STAT, v);
        chk({tag, "_status"}, {32'h0, v}, {63'h0, fired});
        peek(A_CTRL, v);
        chk({tag, "_ctrl"}, {32'h0, v}, {60'h0, m_ie, m_per, 1'b0, go_e});
        chk({tag, "_irq"}, {63'h0, irq}, {63'h0, irq_e});
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_irq", {63'h0, irq}, 64'h0);
        peek(A_LO, d);
        chk("rst_lo_in_reset", {32'h0, d}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 7; a++) begin
            @(negedge clk);
            peek(a[4:0], d);
            chk($sformatf("rst_rd%0d", a), {32'h0, d}, 64'h0);
        end
        chk("rst_irq2", {63'h0, irq}, 64'h0);

        // One-shot, irq enabled
        @(negedge clk);
        start_run(5, 1'b0, 1'b1, 0);
        for (int k = 0; k < 10; k++) begin
            check_state("oneshot");
            @(negedge clk);
        end
        wr(A_STAT, 32'h1);
        peek(A_STAT, d);
        chk("w1c_flag", {32'h0, d}, 64'h0);
        @(negedge clk);
        chk("w1c_irq", {63'h0, irq}, 64'h0);

        // Periodic, W1C colliding with the second match
        start_run(3, 1'b1, 1'b0, 0);
        for (int k = 0; k < 8; k++) begin
            check_state("periodic");
            if (k < 7) @(negedge clk);
        end
        wr(A_STAT, 32'h1);
        check_state("w1c_collide");
        wr(A_STAT, 32'h1);
        peek(A_STAT, d);
        chk("w1c_noncollide", {32'h0, d}, 64'h0);

        // Go + clear while running
        start_run(1000, 1'b0, 1'b0, 0);
        repeat (100) @(negedge clk);
        peek(A_LO, d);
        chk("clr_pre", {32'h0, d}, 64'd100);
        wr(A_CTRL, 32'h3);
        peek(A_LO, d);
        chk("clr_zero", {32'h0, d}, 64'd0);
        @(negedge clk);
        peek(A_LO, d);
        chk("clr_inc1", {32'h0, d}, 64'd1);
        @(negedge clk);
        peek(A_LO, d);
        chk("clr_inc2", {32'h0, d}, 64'd2);

        // Rollover and LO/HI coherency
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        wr(A_CMPL, 32'h0);
        wr(A_CMPH, 32'h0);
        wr(A_PRE, 32'h0);
        force dut.count = 48'hFFFF_FFFF_FFFE;
        #1;
        release dut.count;
        peek(A_LO, d);
        chk("roll_seed", {32'h0, d}, 64'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);
        rd_lo(d);
        chk("roll_lo0", {32'h0, d}, 64'hFFFF_FFFE);
        rd_lo(d);
        chk("roll_lo1", {32'h0, d}, 64'hFFFF_FFFF);
        peek(A_HI, d);
        chk("roll_hi_snap", {32'h0, d}, 64'hFFFF);
        peek(A_LO, d);
        chk("roll_wrapped", {32'h0, d}, 64'h0);
        peek(A_STAT, d);
        chk("roll_noflag", {32'h0, d}, 64'h0);
        @(negedge clk);
        peek(A_STAT, d);
        chk("roll_match0", {32'h0, d}, 64'h1);
        peek(A_CTRL, d);
        chk("roll_go_off", {32'h0, d}, 64'h0);
        rd_lo(d);
        chk("roll_hold", {32'h0, d}, 64'h0);
        peek(A_HI, d);
        chk("roll_hi_new", {32'h0, d}, 64'h0);

        // Prescale (or offset 6 ignored in the default build)
        start_run(4, 1'b1, 1'b1, 2);
        for (int k = 0; k < 20; k++) begin
            check_state("prescale");
            @(negedge clk);
        end

        // Randomized runs
        for (int i = 0; i < 10; i++) begin
            longint c;
            int p, nt;
            bit per, ie;
            c   = longint'($urandom_range(0, 10));
            per = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            p   = int'($urandom_range(0, 3));
            start_run(c, per, ie, p);
            nt = int'($urandom_range(0, 32'((c + 1) * (m_p + 1) * 2 + 3)));
            repeat (nt) @(negedge clk);
            check_state($sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-count
        start_run(32'h1000, 1'b0, 1'b0, 0);
        repeat (32'h123) @(negedge clk);
        peek(A_LO, d);
        chk("arst_pre", {32'h0, d}, 64'h123);
        reset = 1'b0;
        #1;
        peek(A_LO, d);
        chk("arst_cnt", {32'h0, d}, 64'h0);
        peek(A_CTRL, d);
        chk("arst_go", {32'h0, d}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        peek(A_LO, d);
        chk("arst_idle", {32'h0, d}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
